// File: rtl/exe_mdu_stage.sv
// rtl/exe_mdu_stage.sv - iterative multiply/divide execute stage; `MDU_FAST_MUL_EN selects a single-cycle multiplier
module exe_mdu_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             ds_to_es_valid,
    output logic             es_allowin,
    input  logic [2:0]       op,
    input  logic [XLEN-1:0]  src1,
    input  logic [XLEN-1:0]  src2,
    input  logic [TAG_W-1:0] tag_in,
    output logic             es_to_ms_valid,
    input  logic             ms_allowin,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] tag_out,
    output logic             busy
);
    localparam int CNT_W = $clog2(XLEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(XLEN);
    localparam logic [CNT_W-1:0] CNT_SHORT = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [2:0] OP_DIV   = 3'd0;
    localparam logic [2:0] OP_MOD   = 3'd1;
    localparam logic [2:0] OP_DIVU  = 3'd2;
    localparam logic [2:0] OP_MODU  = 3'd3;
    localparam logic [2:0] OP_MULH  = 3'd5;
    localparam logic [2:0] OP_MULHU = 3'd6;

`ifdef MDU_FAST_MUL_EN
    localparam bit FAST_MUL = 1'b1;
`else
    localparam bit FAST_MUL = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic              a_neg_q, a_neg_d, b_neg_q, b_neg_d, b_zero_q, b_zero_d;
    logic [XLEN-1:0]   a_mag_q, a_mag_d, b_mag_q, b_mag_d;
    logic [XLEN:0]     rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [TAG_W-1:0]  tag_q, tag_d, tag_out_q, tag_out_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              accept, in_signed, in_mul, in_neg1, in_neg2, in_short;
    logic [XLEN-1:0]   in_mag1, in_mag2;
    logic [XLEN:0]     div_shift, div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] mul_step, p_fix;
    logic [XLEN-1:0]   q_fix, r_fix, a_orig, fin_result;
    logic              rem_top_unused;

    assign es_allowin     = (state_q == S_IDLE) || ((state_q == S_DONE) && ms_allowin);
    assign accept         = ds_to_es_valid && es_allowin && !flush;
    assign es_to_ms_valid = (state_q == S_DONE);
    assign busy           = (state_q != S_IDLE);
    assign result         = result_q;
    assign tag_out        = tag_out_q;

    // Operand preparation: work on magnitudes, remember signs for the final fix-up
    assign in_signed = (op == OP_DIV) || (op == OP_MOD) || (op == OP_MULH);
    assign in_mul    = op[2];
    assign in_neg1   = in_signed && src1[XLEN-1];
    assign in_neg2   = in_signed && src2[XLEN-1];
    assign in_mag1   = in_neg1 ? -src1 : src1;
    assign in_mag2   = in_neg2 ? -src2 : src2;
    // Zero divisor and fast multiply skip iteration: one step then finish
    assign in_short  = in_mul ? FAST_MUL : (src2 == '0);

    // One restoring-division step; remainder stays below the divisor so its top bit is always clear
    assign div_shift = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
    assign div_ge    = (div_shift >= {1'b0, b_mag_q});
    assign div_diff  = div_shift - {1'b0, b_mag_q};
    assign rem_top_unused = rem_q[XLEN];

`ifdef MDU_FAST_MUL_EN
    assign mul_step = {{XLEN{1'b0}}, a_mag_q} * {{XLEN{1'b0}}, b_mag_q};
`else
    // One shift-add step: low half holds the unconsumed multiplier bits
    logic [XLEN:0] mul_add;
    assign mul_add  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, a_mag_q} : '0);
    assign mul_step = {mul_add, prod_q[XLEN-1:1]};
`endif

    assign q_fix  = (a_neg_q ^ b_neg_q) ? -quo_q : quo_q;
    assign r_fix  = a_neg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
    assign p_fix  = (a_neg_q ^ b_neg_q) ? -prod_q : prod_q;
    assign a_orig = a_neg_q ? -a_mag_q : a_mag_q;

    // Final result selection including zero-divisor corner cases
    always_comb begin
        fin_result = p_fix[XLEN-1:0];
        case (op_q)
            OP_DIV, OP_DIVU:   fin_result = b_zero_q ? '1 : q_fix;
            OP_MOD, OP_MODU:   fin_result = b_zero_q ? a_orig : r_fix;
            OP_MULH, OP_MULHU: fin_result = p_fix[2*XLEN-1:XLEN];
            default:           fin_result = p_fix[XLEN-1:0];
        endcase
    end

    // Next-state and datapath update; flush overrides everything
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_neg_d   = a_neg_q;
        b_neg_d   = b_neg_q;
        b_zero_d  = b_zero_q;
        a_mag_d   = a_mag_q;
        b_mag_d   = b_mag_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        prod_d    = prod_q;
        tag_d     = tag_q;
        tag_out_d = tag_out_q;
        result_d  = result_q;
        case (state_q)
            S_BUSY: begin
                if (cnt_q == CNT_LAST) begin
                    state_d   = S_DONE;
                    cnt_d     = '0;
                    result_d  = fin_result;
                    tag_out_d = tag_q;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (op_q[2]) begin
                        prod_d = mul_step;
                    end else begin
                        rem_d = div_ge ? div_diff : div_shift;
                        quo_d = {quo_q[XLEN-2:0], div_ge};
                    end
                end
            end
            S_DONE: begin
                if (ms_allowin) state_d = S_IDLE;
            end
            default: ;
        endcase
        if (accept) begin
            state_d  = S_BUSY;
            cnt_d    = in_short ? CNT_SHORT : '0;
            op_d     = op;
            a_neg_d  = in_neg1;
            b_neg_d  = in_neg2;
            b_zero_d = (src2 == '0);
            a_mag_d  = in_mag1;
            b_mag_d  = in_mag2;
            rem_d    = '0;
            quo_d    = in_mag1;
            prod_d   = {{XLEN{1'b0}}, in_mag2};
            tag_d    = tag_in;
        end
        if (flush) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            result_d  = result_q;
            tag_out_d = tag_out_q;
        end
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            a_neg_q   <= 1'b0;
            b_neg_q   <= 1'b0;
            b_zero_q  <= 1'b0;
            a_mag_q   <= '0;
            b_mag_q   <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            prod_q    <= '0;
            tag_q     <= '0;
            tag_out_q <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            a_neg_q   <= a_neg_d;
            b_neg_q   <= b_neg_d;
            b_zero_q  <= b_zero_d;
            a_mag_q   <= a_mag_d;
            b_mag_q   <= b_mag_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            prod_q    <= prod_d;
            tag_q     <= tag_d;
            tag_out_q <= tag_out_d;
            result_q  <= result_d;
        end
    end
endmodule

// File: tb/tb_exe_mdu_stage.sv
// tb/tb_exe_mdu_stage.sv - scoreboard testbench for exe_mdu_stage
module tb_exe_mdu_stage;
`ifdef MDU_FAST_MUL_EN
    localparam int ML = 2;
`else
    localparam int ML = 33;
`endif
    localparam int DL = 33;
    localparam int ZL = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        flush = 1'b0;
    logic        ds_to_es_valid = 1'b0;
    logic        ms_allowin = 1'b1;
    logic [2:0]  op = '0;
    logic [31:0] src1 = '0;
    logic [31:0] src2 = '0;
    logic [4:0]  tag_in = '0;
    logic        es_allowin, es_to_ms_valid, busy;
    logic [31:0] result;
    logic [4:0]  tag_out;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          acc;
        int          lat;
    } sb_t;

    sb_t sb_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;

    exe_mdu_stage #(.XLEN(32), .TAG_W(5)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .ds_to_es_valid(ds_to_es_valid), .es_allowin(es_allowin),
        .op(op), .src1(src1), .src2(src2), .tag_in(tag_in),
        .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
        .result(result), .tag_out(tag_out), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] t, input logic [31:0] exp_r, input int lat, input bit push);
        int n = 0;
        op = o; src1 = a; src2 = b; tag_in = t; ds_to_es_valid = 1'b1;
        #1;
        while (!es_allowin && n < 200) begin
            @(negedge clk); #1; n++;
        end
        if (!es_allowin) begin
            checks++; errors++;
            $display("FAIL issue_timeout actual=%0d required=es_allowin", n);
        end else if (push) begin
            sb_q.push_back('{exp_r, t, cyc + 1, lat});
        end
        @(posedge clk); #1;
        ds_to_es_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 500) begin
            @(negedge clk); n++;
        end
        @(posedge clk); #1;
    endtask

    // Monitor: every result handshake is matched against the oldest expectation
    initial begin
        sb_t item;
        forever begin
            @(negedge clk);
            if (resetn && es_to_ms_valid && ms_allowin) begin
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_result actual=%h tag=%h required=none", result, tag_out);
                end else begin
                    item = sb_q.pop_front();
                    chk("sb_result", result, item.res);
                    chk("sb_tag", {27'b0, tag_out}, {27'b0, item.tag});
                    if (item.lat > 0) chk("sb_latency", cyc - item.acc, item.lat);
                end
            end
        end
    end

    initial begin
        int n;
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'b0, es_to_ms_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_tag", {27'b0, tag_out}, 32'd0);
        chk("rst_allowin", {31'b0, es_allowin}, 32'd1);
        @(posedge clk); #1;
        resetn = 1'b1;

        issue(3'd0, 32'hFFFFFFF9, 32'd2,        5'd1,  32'hFFFFFFFD, DL, 1);
        issue(3'd1, 32'hFFFFFFF9, 32'd2,        5'd2,  32'hFFFFFFFF, DL, 1);
        issue(3'd2, 32'd100,      32'd0,        5'd3,  32'hFFFFFFFF, ZL, 1);
        issue(3'd3, 32'd100,      32'd0,        5'd4,  32'd100,      ZL, 1);
        issue(3'd0, 32'h80000000, 32'hFFFFFFFF, 5'd5,  32'h80000000, DL, 1);
        issue(3'd1, 32'h80000000, 32'hFFFFFFFF, 5'd6,  32'd0,        DL, 1);
        issue(3'd5, 32'h80000000, 32'h80000000, 5'd7,  32'h40000000, ML, 1);
        issue(3'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFE, ML, 1);
        issue(3'd4, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9,  32'h00000001, ML, 1);
        issue(3'd2, 32'hFFFFFFFF, 32'd16,       5'd10, 32'h0FFFFFFF, DL, 1);
        issue(3'd3, 32'hFFFFFFFF, 32'd16,       5'd11, 32'h0000000F, DL, 1);
        issue(3'd0, 32'd7,        32'hFFFFFFFE, 5'd12, 32'hFFFFFFFD, DL, 1);
        issue(3'd1, 32'd7,        32'hFFFFFFFE, 5'd13, 32'h00000001, DL, 1);
        issue(3'd4, 32'hFFFFFFFD, 32'd5,        5'd14, 32'hFFFFFFF1, ML, 1);
        issue(3'd5, 32'hFFFFFFFD, 32'd5,        5'd15, 32'hFFFFFFFF, ML, 1);
        issue(3'd0, 32'hFFFFFFFB, 32'd0,        5'd16, 32'hFFFFFFFF, ZL, 1);
        issue(3'd1, 32'hFFFFFFFB, 32'd0,        5'd17, 32'hFFFFFFFB, ZL, 1);
        issue(3'd6, 32'h12345678, 32'h10,       5'd18, 32'h00000001, ML, 1);
        issue(3'd4, 32'h12345678, 32'h10,       5'd19, 32'h23456780, ML, 1);

        // Memory stage stalls: result must be held in DONE
        wait_drain();
        ms_allowin = 1'b0;
        issue(3'd0, 32'd100, 32'd7, 5'd9, 32'd14, 0, 1);
        n = 0;
        while (!es_to_ms_valid && n < 100) begin
            @(negedge clk); n++;
        end
        chk("hold_reach_valid", {31'b0, es_to_ms_valid}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'b0, es_to_ms_valid}, 32'd1);
            chk("hold_result", result, 32'd14);
            chk("hold_tag", {27'b0, tag_out}, 32'd9);
            chk("hold_allowin", {31'b0, es_allowin}, 32'd0);
        end
        @(posedge clk); #1;
        ms_allowin = 1'b1;
        issue(3'd4, 32'd7, 32'd6, 5'd10, 32'd42, ML, 1);

        // Flush five cycles into a divide
        wait_drain();
        issue(3'd0, 32'd50, 32'd3, 5'd3, 32'd0, 0, 0);
        repeat (4) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_allowin", {31'b0, es_allowin}, 32'd1);
        chk("flush_valid", {31'b0, es_to_ms_valid}, 32'd0);
        chk("flush_busy", {31'b0, busy}, 32'd0);
        issue(3'd0, 32'd50, 32'd3, 5'd4, 32'd16, DL, 1);

        // Asynchronous reset in the middle of an operation
        wait_drain();
        issue(3'd3, 32'd1000, 32'd7, 5'd7, 32'd0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("mid_rst_valid", {31'b0, es_to_ms_valid}, 32'd0);
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_result", result, 32'd0);
        chk("mid_rst_tag", {27'b0, tag_out}, 32'd0);
        chk("mid_rst_allowin", {31'b0, es_allowin}, 32'd1);
        @(posedge clk); #1;
        resetn = 1'b1;
        issue(3'd2, 32'd1000, 32'd7, 5'd11, 32'd142, DL, 1);
        issue(3'd3, 32'd1000, 32'd7, 5'd12, 32'd6,   DL, 1);

        wait_drain();
        chk("drain_empty", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
